// File: rtl/asp_irq_ctrl.sv
// ---------------------------------------------------------------------------
// asp_irq_ctrl
//   Aggregates the ASP AVMM-side interrupt sources (bit 0 = DMA_0,
//   bit 1 = kernel, bit 2 = DMA_1). Rising edges on each source are latched
//   into a sticky STATUS register. STATUS is masked by a host-programmed
//   ENABLE register. One interrupt at a time is forwarded to the host channel
//   over a req/ack handshake.
//
// Ports
//   clk_i                 ASP clock; all logic runs on the rising edge
//   reset_i               synchronous, active-high reset
//   irq_in_i              level interrupt sources, synchronous to clk_i
//   avmm_address_i        CSR qword index
//   avmm_read_i           read command
//   avmm_write_i          write command
//   avmm_writedata_i      write data (only bits [NUM_IRQ-1:0] are used)
//   avmm_byteenable_i     byte enables (only byte 0 is used)
//   avmm_readdata_o       registered read data
//   avmm_readdatavalid_o  read strobe, 1 cycle after avmm_read_i
//   avmm_waitrequest_o    tied to 0
//   irq_req_o             interrupt request to the host channel
//   irq_vec_o             index of the source being signalled
//   irq_ack_i             1-cycle acceptance of irq_req_o
//
// CSR map (qword index)
//   0 STATUS  RO, W1C    1 ENABLE  RW    2 PENDING  RO
//   3 RAW     RO         4 SET     WO, W1S (reads 0)
//   5..7      read 0
// ---------------------------------------------------------------------------
module asp_irq_ctrl #(
    parameter int NUM_IRQ    = 3,
    parameter int VEC_W      = 2,
    parameter int CSR_ADDR_W = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NUM_IRQ-1:0]    irq_in_i,
    input  logic [CSR_ADDR_W-1:0] avmm_address_i,
    input  logic                  avmm_read_i,
    input  logic                  avmm_write_i,
    input  logic [63:0]           avmm_writedata_i,
    input  logic [7:0]            avmm_byteenable_i,
    output logic [63:0]           avmm_readdata_o,
    output logic                  avmm_readdatavalid_o,
    output logic                  avmm_waitrequest_o,
    output logic                  irq_req_o,
    output logic [VEC_W-1:0]      irq_vec_o,
    input  logic                  irq_ack_i
);

    localparam logic [CSR_ADDR_W-1:0] A_STATUS  = CSR_ADDR_W'(0);
    localparam logic [CSR_ADDR_W-1:0] A_ENABLE  = CSR_ADDR_W'(1);
    localparam logic [CSR_ADDR_W-1:0] A_PENDING = CSR_ADDR_W'(2);
    localparam logic [CSR_ADDR_W-1:0] A_RAW     = CSR_ADDR_W'(3);
    localparam logic [CSR_ADDR_W-1:0] A_SET     = CSR_ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_CLR = 2'd2
    } state_e;

    state_e               state_q;
    logic [NUM_IRQ-1:0]   status_q, status_d;
    logic [NUM_IRQ-1:0]   enable_q;
    logic [NUM_IRQ-1:0]   prev_irq_q;
    logic [63:0]          rdata_q, rdata_d;
    logic                 rvalid_q;
    logic                 irq_req_q;
    logic [VEC_W-1:0]     irq_vec_q;

    logic [NUM_IRQ-1:0]   rise, clr_wr, set_wr, pending, wdat;
    logic                 wr_ok;
    logic [VEC_W-1:0]     low_idx;
    logic                 vec_pend;

    // Only byte 0 of the bus carries CSR bits.
    logic unused_bus;
    assign unused_bus = ^{avmm_writedata_i[63:NUM_IRQ], avmm_byteenable_i[7:1]};

    assign wr_ok   = avmm_write_i & avmm_byteenable_i[0];
    assign wdat    = avmm_writedata_i[NUM_IRQ-1:0];
    assign clr_wr  = (wr_ok && avmm_address_i == A_STATUS) ? wdat : '0;
    assign set_wr  = (wr_ok && avmm_address_i == A_SET)    ? wdat : '0;
    assign rise    = irq_in_i & ~prev_irq_q;
    assign pending = status_q & enable_q;

    // A new edge or a SET write wins over a same-cycle W1C.
    assign status_d = rise | set_wr | (status_q & ~clr_wr);

    // Lowest pending index, and whether the source in service is still pending.
    always_comb begin
        low_idx  = '0;
        vec_pend = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) low_idx = VEC_W'(i);
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_vec_q == VEC_W'(i)) vec_pend = pending[i];
        end
    end

    // Read mux sees pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rdata_d = '0;
        unique case (avmm_address_i)
            A_STATUS:  rdata_d[NUM_IRQ-1:0] = status_q;
            A_ENABLE:  rdata_d[NUM_IRQ-1:0] = enable_q;
            A_PENDING: rdata_d[NUM_IRQ-1:0] = pending;
            A_RAW:     rdata_d[NUM_IRQ-1:0] = irq_in_i;
            default:   rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            status_q   <= '0;
            enable_q   <= '0;
            // Track the input through reset so a level held across reset is
            // not mistaken for a fresh edge once reset releases.
            prev_irq_q <= irq_in_i;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            status_q   <= status_d;
            prev_irq_q <= irq_in_i;
            rvalid_q   <= avmm_read_i;
            if (avmm_read_i) rdata_q <= rdata_d;
            if (wr_ok && avmm_address_i == A_ENABLE) enable_q <= wdat;
        end
    end

    // Request FSM: one source in flight; it must be cleared (or masked) by the
    // host before the next one is offered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
            irq_vec_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pending != '0) begin
                        irq_vec_q <= low_idx;
                        irq_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        irq_req_q <= 1'b0;
                        state_q   <= WAIT_CLR;
                    end
                end
                WAIT_CLR: begin
                    if (!vec_pend) state_q <= IDLE;
                end
                default: begin
                    irq_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign avmm_readdata_o      = rdata_q;
    assign avmm_readdatavalid_o = rvalid_q;
    assign avmm_waitrequest_o   = 1'b0;
    assign irq_req_o            = irq_req_q;
    assign irq_vec_o            = irq_vec_q;

endmodule
